// File: rtl/video_timing_pkg.sv
// Shared timing types and standard video mode constants for the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } timing_t;

    localparam timing_t Timing800x600p60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    localparam timing_t Timing640x480p60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: wrapping position counter with terminal-count flag and
// active/sync region decode taken straight from the count register.
module sync_axis_counter #(
    parameter int unsigned ACTIVE = 4,
    parameter int unsigned FP     = 1,
    parameter int unsigned SYNC   = 1,
    parameter int unsigned BP     = 1,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         tc_o,
    output logic         active_o,
    output logic         sync_o
);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
        $fatal(1, "sync_axis_counter: ACTIVE, FP, SYNC and BP must all be >= 1");
    end

    localparam logic [W-1:0] LastCount = W'(TOTAL - 1);
    localparam logic [W-1:0] ActiveEnd = W'(ACTIVE);
    localparam logic [W-1:0] SyncStart = W'(ACTIVE + FP);
    localparam logic [W-1:0] SyncEnd   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LastCount) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign tc_o     = (count_q == LastCount);
    assign active_o = (count_q < ActiveEnd);
    assign sync_o   = (count_q >= SyncStart) && (count_q < SyncEnd);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters advanced by a pixel tick, with
// zero-latency DE, sync and frame markers decoded from the current position.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = Timing800x600p60.h_active,
    parameter int unsigned H_FP      = Timing800x600p60.h_fp,
    parameter int unsigned H_SYNC    = Timing800x600p60.h_sync,
    parameter int unsigned H_BP      = Timing800x600p60.h_bp,
    parameter int unsigned V_ACTIVE  = Timing800x600p60.v_active,
    parameter int unsigned V_FP      = Timing800x600p60.v_fp,
    parameter int unsigned V_SYNC    = Timing800x600p60.v_sync,
    parameter int unsigned V_BP      = Timing800x600p60.v_bp,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HLEN     = $clog2(H_TOTAL),
    localparam int unsigned VLEN     = $clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc,
    input  logic            i_clr,
    output logic [HLEN-1:0] o_hcount,
    output logic [VLEN-1:0] o_vcount,
    output logic            o_de,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_line_end,
    output logic            o_frame_start,
    output logic            o_frame_end
);

    logic h_tc, h_active, h_sync;
    logic v_tc, v_active, v_sync;

    sync_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .en_i     (i_inc),
        .clr_i    (i_clr),
        .count_o  (o_hcount),
        .tc_o     (h_tc),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    // Lines advance only on the pixel tick that wraps the horizontal counter.
    sync_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .en_i     (i_inc & h_tc),
        .clr_i    (i_clr),
        .count_o  (o_vcount),
        .tc_o     (v_tc),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    assign o_de          = h_active & v_active;
    assign o_hsync       = HSYNC_POL ? h_sync : ~h_sync;
    assign o_vsync       = VSYNC_POL ? v_sync : ~v_sync;
    assign o_line_end    = h_tc;
    assign o_frame_start = (o_hcount == '0) && (o_vcount == '0);
    assign o_frame_end   = h_tc & v_tc;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a tiny 8x6 raster, two instances
// differing only in hsync polarity, compared against a position-level model.
module tb_video_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_inc = 1'b0;
    logic       i_clr = 1'b0;

    logic [2:0] a_hc, a_vc, b_hc, b_vc;
    logic       a_de, a_hs, a_vs, a_le, a_fs, a_fe;
    logic       b_de, b_hs, b_vs, b_le, b_fs, b_fe;
    logic [11:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;
    int mh = 0;
    int mv = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .i_inc(i_inc), .i_clr(i_clr),
        .o_hcount(a_hc), .o_vcount(a_vc), .o_de(a_de), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_line_end(a_le), .o_frame_start(a_fs), .o_frame_end(a_fe)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .i_inc(i_inc), .i_clr(i_clr),
        .o_hcount(b_hc), .o_vcount(b_vc), .o_de(b_de), .o_hsync(b_hs), .o_vsync(b_vs),
        .o_line_end(b_le), .o_frame_start(b_fs), .o_frame_end(b_fe)
    );

    assign obs_a = {a_hc, a_vc, a_de, a_hs, a_vs, a_le, a_fs, a_fe};
    assign obs_b = {b_hc, b_vc, b_de, b_hs, b_vs, b_le, b_fs, b_fe};

    // Reference outputs for a raster position, straight from the region definitions.
    function automatic logic [11:0] exp_out(input int h, input int v, input bit hpol);
        bit de, hs_on, vs_on, le, fs, fe;
        de    = (h < HA) && (v < VA);
        hs_on = (h >= HA + HF) && (h < HA + HF + HS);
        vs_on = (v >= VA + VF) && (v < VA + VF + VS);
        le    = (h == HT - 1);
        fs    = (h == 0) && (v == 0);
        fe    = (h == HT - 1) && (v == VT - 1);
        return {3'(h), 3'(v), de, (hpol ? hs_on : !hs_on), vs_on, le, fs, fe};
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, return at the falling edge.
    task automatic step(input bit inc, input bit clr, input bit r);
        rst   = r;
        i_clr = clr;
        i_inc = inc;
        @(posedge clk);
        if (r || clr) begin
            mh = 0;
            mv = 0;
        end else if (inc) begin
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom), 1'b1);
            checks++;
            if (obs_a !== 12'b000_000_1_0_0_0_1_0) begin
                errors++;
                $display("FAIL reset_a cycle %0d: got %b want %b", i, obs_a,
                         12'b000_000_1_0_0_0_1_0);
            end
            checks++;
            if (obs_b !== 12'b000_000_1_1_0_0_1_0) begin
                errors++;
                $display("FAIL reset_b cycle %0d: got %b want %b", i, obs_b,
                         12'b000_000_1_1_0_0_1_0);
            end
        end
    endtask

    task automatic test_sequence();
        int fe_seen = 0;
        for (int i = 1; i <= 48; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (a_fe === 1'b1) fe_seen++;
            checks++;
            if (obs_a !== exp_out(mh, mv, 1'b1) || obs_b !== exp_out(mh, mv, 1'b0)) begin
                errors++;
                $display("FAIL seq cycle %0d: got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b,
                         exp_out(mh, mv, 1'b1), exp_out(mh, mv, 1'b0));
            end
            checks++;
            if (a_hc !== 3'(i % 8) || a_hs !== ((i % 8) == 5 || (i % 8) == 6)
                || a_vs !== (((i / 8) % 6) == 4)) begin
                errors++;
                $display("FAIL seq_literal cycle %0d: got hc=%0d hs=%b vs=%b want hc=%0d",
                         i, a_hc, a_hs, a_vs, i % 8);
            end
        end
        checks++;
        if (fe_seen != 1) begin
            errors++;
            $display("FAIL frame_end_count: got %0d want 1", fe_seen);
        end
    endtask

    task automatic test_hold();
        int  frame_cycles = 0;
        bit  left_origin  = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 200 && frame_cycles == 0; k++) begin
            step(1'(k % 2 == 0), 1'b0, 1'b0);
            checks++;
            if (obs_a !== exp_out(mh, mv, 1'b1) || obs_b !== exp_out(mh, mv, 1'b0)) begin
                errors++;
                $display("FAIL hold cycle %0d: got a=%b b=%b want a=%b b=%b", k, obs_a, obs_b,
                         exp_out(mh, mv, 1'b1), exp_out(mh, mv, 1'b0));
            end
            if (a_fs !== 1'b1) left_origin = 1'b1;
            else if (left_origin) frame_cycles = k;
        end
        checks++;
        if (frame_cycles != 96) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles want 96", frame_cycles);
        end
    endtask

    task automatic test_clear();
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 2 * HT + 6; i++) step(1'b1, 1'b0, 1'b0);
            checks++;
            if (a_hc !== 3'd6 || a_vc !== 3'd2) begin
                errors++;
                $display("FAIL clr_setup pass %0d: got (%0d,%0d) want (6,2)", pass, a_hc, a_vc);
            end
            step(1'(pass == 0), 1'b1, 1'b0);
            checks++;
            if (a_hc !== 3'd0 || a_vc !== 3'd0 || a_fs !== 1'b1 || b_fs !== 1'b1) begin
                errors++;
                $display("FAIL clr pass %0d: got (%0d,%0d) fs=%b want (0,0) fs=1",
                         pass, a_hc, a_vc, a_fs);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4 * HT + 3; i++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (a_hc !== 3'd3 || a_vc !== 3'd4) begin
            errors++;
            $display("FAIL rst_setup: got (%0d,%0d) want (3,4)", a_hc, a_vc);
        end
        step(1'($urandom), 1'b1, 1'b1);
        checks++;
        if (obs_a !== 12'b000_000_1_0_0_0_1_0 || obs_b !== 12'b000_000_1_1_0_0_1_0) begin
            errors++;
            $display("FAIL rst_mid: got a=%b b=%b want a=%b b=%b", obs_a, obs_b,
                     12'b000_000_1_0_0_0_1_0, 12'b000_000_1_1_0_0_1_0);
        end
        for (int i = 1; i <= HT; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (b_hs !== !((i % 8) == 5 || (i % 8) == 6)) begin
                errors++;
                $display("FAIL hsync_low_pol hc=%0d: got %b want %b", i % 8, b_hs,
                         !((i % 8) == 5 || (i % 8) == 6));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 99) == 0));
            checks++;
            if (obs_a !== exp_out(mh, mv, 1'b1) || obs_b !== exp_out(mh, mv, 1'b0)) begin
                errors++;
                $display("FAIL random cycle %0d: got a=%b b=%b want a=%b b=%b", i, obs_a,
                         obs_b, exp_out(mh, mv, 1'b1), exp_out(mh, mv, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
